// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive path.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_t;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ERR_CNT_W  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push is visible on rd_dat/level the cycle after it is accepted.
// A push into a full FIFO is only taken alongside a pop; rd_dat reads 0 while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != FULL_LVL) || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign rd_dat = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame receive controller: syncs rx_busy, commits each finished frame into a byte FIFO.
// Byte visible 2 cycles after synced busy falls; full FIFO drops the byte and flags overrun.
module rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          rx_en,
  input  logic                          rx_busy,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_parity_ok,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [ERR_CNT_W-1:0]          parity_err_cnt,
  input  logic                          status_clr
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic      busy_meta;
  logic      busy_s;
  logic      busy_d;
  logic      busy_rise;
  logic      busy_fall;
  rx_state_t state;
  rx_state_t state_nxt;
  logic      commit;
  logic      pop;
  logic      has_space;
  logic      push;
  logic      ovr_set;
  logic      perr_inc;

  // busy_d is the edge-detect history, not a third sync stage.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
      busy_d    <= 1'b0;
    end else begin
      busy_meta <= rx_busy;
      busy_s    <= busy_meta;
      busy_d    <= busy_s;
    end
  end

  assign busy_rise = busy_s & ~busy_d;
  assign busy_fall = ~busy_s & busy_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE:   if (busy_rise && rx_en) state_nxt = ST_RECV;
      ST_RECV:   if (busy_fall)          state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign rd_valid  = (fifo_level != '0);
  assign pop       = rd_valid & rd_ready;
  // A same-cycle pop frees the slot the commit needs.
  assign has_space = (fifo_level != FULL_LVL) | pop;
  assign push      = commit & rx_parity_ok & has_space;
  assign ovr_set   = commit & rx_parity_ok & ~has_space;
  assign perr_inc  = commit & ~rx_parity_ok;

  // Set/increment takes priority over a coincident clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
    end else begin
      if (ovr_set)         overrun <= 1'b1;
      else if (status_clr) overrun <= 1'b0;

      if (perr_inc) begin
        if (status_clr)                   parity_err_cnt <= ERR_CNT_W'(1);
        else if (parity_err_cnt != '1)    parity_err_cnt <= parity_err_cnt + 1'b1;
      end else if (status_clr) begin
        parity_err_cnt <= '0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (rx_data),
    .pop      (pop),
    .rd_dat   (rd_data),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a byte scoreboard and status model.
module tb_rx_frame_ctrl;

  localparam int DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       rx_en;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_parity_ok;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [2:0] fifo_level;
  logic       overrun;
  logic [7:0] parity_err_cnt;
  logic       status_clr;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  logic       exp_ovr = 1'b0;
  int         exp_cnt = 0;
  logic       commit_clr = 1'b0;
  logic       commit_pop = 1'b0;

  always #5 sys_clk = ~sys_clk;

  rx_frame_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .ERR_CNT_W  (8)
  ) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .rx_en          (rx_en),
    .rx_busy        (rx_busy),
    .rx_data        (rx_data),
    .rx_parity_ok   (rx_parity_ok),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .fifo_level     (fifo_level),
    .overrun        (overrun),
    .parity_err_cnt (parity_err_cnt),
    .status_clr     (status_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, 32'(fifo_level), 32'(sb.size()));
    check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    check({tag, "_cnt"}, 32'(parity_err_cnt), 32'(exp_cnt));
  endtask

  task automatic frame(input logic [7:0] d, input logic par, input logic en0,
                       input logic en1, input int hi);
    logic full;
    rx_en   = en0;
    rx_busy = 1'b1;
    tick(hi);
    rx_en        = en1;
    rx_busy      = 1'b0;
    rx_data      = d;
    rx_parity_ok = par;
    tick(3);
    if (sb.size() == 0) check("commit_rdv", 32'(rd_valid), 32'd0);
    status_clr = commit_clr;
    rd_ready   = commit_pop;
    if (commit_pop && sb.size() > 0) begin
      check("commit_pop_dat", 32'(rd_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    full = (sb.size() >= DEPTH);
    if (en0 && par && !full) sb.push_back(d);
    if (en0 && par && full) exp_ovr = 1'b1;
    else if (commit_clr)    exp_ovr = 1'b0;
    if (en0 && !par) exp_cnt = commit_clr ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
    else if (commit_clr) exp_cnt = 0;
    tick(1);
    status_clr = 1'b0;
    rd_ready   = 1'b0;
    check_status("frame");
  endtask

  task automatic pop_check(input string tag);
    int i;
    logic exp_v;
    exp_v = (sb.size() != 0);
    i = 0;
    while (exp_v && !rd_valid && i < 20) begin
      tick(1);
      i++;
    end
    check({tag, "_rdv"}, 32'(rd_valid), 32'(exp_v));
    if (exp_v && rd_valid) begin
      check({tag, "_dat"}, 32'(rd_data), 32'(sb[0]));
      void'(sb.pop_front());
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
    end
    check({tag, "_lvl"}, 32'(fifo_level), 32'(sb.size()));
  endtask

  task automatic clear_status();
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    exp_ovr = 1'b0;
    exp_cnt = 0;
    check_status("clr");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdv"}, 32'(rd_valid), 32'd0);
    check({tag, "_lvl"}, 32'(fifo_level), 32'd0);
    check({tag, "_dat"}, 32'(rd_data), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_cnt"}, 32'(parity_err_cnt), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    rx_en        = 1'b0;
    rx_busy      = 1'b0;
    rx_data      = 8'h00;
    rx_parity_ok = 1'b0;
    rd_ready     = 1'b0;
    status_clr   = 1'b0;
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // single good frame, latency and data
    frame(8'hA5, 1'b1, 1'b1, 1'b1, 10);
    pop_check("a5");

    // bad parity
    frame(8'h3C, 1'b0, 1'b1, 1'b1, 10);

    // overrun with five frames into a depth-4 buffer
    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b1, 1'b1, 6);
    check("ovr_full_level", 32'(fifo_level), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ovr_drain");

    // full buffer with a pop during commit
    clear_status();
    for (int i = 8'h11; i <= 8'h14; i++) frame(8'(i), 1'b1, 1'b1, 1'b1, 6);
    commit_pop = 1'b1;
    frame(8'h55, 1'b1, 1'b1, 1'b1, 6);
    commit_pop = 1'b0;
    check("fullpop_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("fullpop_drain");

    // rd_ready on an empty buffer
    rd_ready = 1'b1;
    tick(2);
    rd_ready = 1'b0;
    check("empty_rdy_lvl", 32'(fifo_level), 32'd0);
    check("empty_rdy_rdv", 32'(rd_valid), 32'd0);

    // disabled at frame start, then enable dropped mid-frame
    frame(8'h66, 1'b1, 1'b0, 1'b0, 6);
    frame(8'h42, 1'b1, 1'b1, 1'b0, 6);
    pop_check("en_mid");

    // counter saturation and clear
    repeat (256) frame(8'h3C, 1'b0, 1'b1, 1'b1, 4);
    check("sat_cnt", 32'(parity_err_cnt), 32'd255);
    clear_status();
    frame(8'h3C, 1'b0, 1'b1, 1'b1, 4);
    commit_clr = 1'b1;
    frame(8'h3C, 1'b0, 1'b1, 1'b1, 4);
    commit_clr = 1'b0;
    check("clr_vs_inc", 32'(parity_err_cnt), 32'd1);

    // reset mid-frame with two bytes buffered
    frame(8'h21, 1'b1, 1'b1, 1'b1, 6);
    frame(8'h22, 1'b1, 1'b1, 1'b1, 6);
    rx_en   = 1'b1;
    rx_busy = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    rx_busy = 1'b0;
    sb.delete();
    exp_ovr = 1'b0;
    exp_cnt = 0;
    #2;
    rst_n = 1'b1;
    tick(3);
    frame(8'h7E, 1'b1, 1'b1, 1'b1, 10);
    pop_check("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
